// File: rtl/operand_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage_pkg
// Shared types for the operand fetch stage and its register scoreboard.
//   t_data           : one architectural data word
//   t_register_index : architectural register index
//   t_scoreboard     : one pending bit per architectural register
//   REG_X0           : index of the hard-wired zero register
// -----------------------------------------------------------------------------
package operand_fetch_stage_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int REG_IDX_W    = $clog2(NUM_REGS_DEF);

   typedef logic [XLEN_DEF-1:0]     t_data;
   typedef logic [REG_IDX_W-1:0]    t_register_index;
   typedef logic [NUM_REGS_DEF-1:0] t_scoreboard;

   localparam t_register_index REG_X0 = '0;

endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Pending-writer mask for the architectural registers. A bit is set when an
// instruction that writes the register is issued and cleared when writeback
// retires it or when the issuing instruction is flushed before leaving the
// stage. Bit 0 (x0) is never set.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_set_en / i_set_idx           mark register pending (issue)
//   i_clr_en / i_clr_idx           clear register (writeback)
//   i_flush_clr_en / _idx          clear register (flushed held instruction)
//   i_lkpN_idx / o_lkpN_pend       three combinational lookups (rs1, rs2, rd)
// -----------------------------------------------------------------------------
module reg_scoreboard
   import operand_fetch_stage_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_set_en,
   input  t_register_index i_set_idx,
   input  logic            i_clr_en,
   input  t_register_index i_clr_idx,
   input  logic            i_flush_clr_en,
   input  t_register_index i_flush_clr_idx,
   input  t_register_index i_lkp1_idx,
   input  t_register_index i_lkp2_idx,
   input  t_register_index i_lkp3_idx,
   output logic            o_lkp1_pend,
   output logic            o_lkp2_pend,
   output logic            o_lkp3_pend
);

   t_scoreboard pending_q;
   t_scoreboard pending_d;

   // Clears are applied before the set so that a same-cycle issue to a
   // register being retired leaves it pending for the new writer.
   always_comb begin
      pending_d = pending_q;
      if (i_clr_en) begin
         pending_d[i_clr_idx] = 1'b0;
      end
      if (i_flush_clr_en) begin
         pending_d[i_flush_clr_idx] = 1'b0;
      end
      if (i_set_en) begin
         pending_d[i_set_idx] = 1'b1;
      end
      pending_d[REG_X0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign o_lkp1_pend = pending_q[i_lkp1_idx];
   assign o_lkp2_pend = pending_q[i_lkp2_idx];
   assign o_lkp3_pend = pending_q[i_lkp3_idx];

endmodule

// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
// Sits between decode and execute. Presents rs1/rs2 to the register file's
// asynchronous read ports, captures the operands and pass-through fields into
// an output register, and stalls on RAW/WAW hazards against in-flight
// destinations tracked by reg_scoreboard. Valid/ready on both sides.
// Optional build macro:
//   WB_BYPASS_EN : a writeback in the issue cycle forwards i_wb_data into a
//                  matching operand and hides that register's pending bit
//                  from the hazard check, removing the one-cycle stall.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_valid/o_ready            upstream handshake
//   i_rs1,i_rs2,i_rd,i_rd_write,i_pc,i_imm   decoded instruction
//   o_rf_idx1/2, i_rf_data1/2  register file read port
//   i_wb_enable,i_wb_idx,i_wb_data           writeback retire port
//   i_flush                    discard the held output instruction
//   o_valid/i_ready            downstream handshake
//   o_op1,o_op2,o_pc,o_imm,o_rd,o_rd_write   captured instruction
// -----------------------------------------------------------------------------
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF
)(
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [$clog2(NUM_REGS)-1:0] i_rs1,
   input  logic [$clog2(NUM_REGS)-1:0] i_rs2,
   input  logic [$clog2(NUM_REGS)-1:0] i_rd,
   input  logic                        i_rd_write,
   input  logic [XLEN-1:0]             i_pc,
   input  logic [XLEN-1:0]             i_imm,
   output logic [$clog2(NUM_REGS)-1:0] o_rf_idx1,
   output logic [$clog2(NUM_REGS)-1:0] o_rf_idx2,
   input  logic [XLEN-1:0]             i_rf_data1,
   input  logic [XLEN-1:0]             i_rf_data2,
   input  logic                        i_wb_enable,
   input  logic [$clog2(NUM_REGS)-1:0] i_wb_idx,
   input  logic [XLEN-1:0]             i_wb_data,
   input  logic                        i_flush,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [XLEN-1:0]             o_op1,
   output logic [XLEN-1:0]             o_op2,
   output logic [XLEN-1:0]             o_pc,
   output logic [XLEN-1:0]             o_imm,
   output logic [$clog2(NUM_REGS)-1:0] o_rd,
   output logic                        o_rd_write
);

   logic            valid_q,    valid_d;
   t_data           op1_q,      op1_d;
   t_data           op2_q,      op2_d;
   t_data           pc_q,       pc_d;
   t_data           imm_q,      imm_d;
   t_register_index rd_q,       rd_d;
   logic            rd_write_q, rd_write_d;

   logic pend_rs1, pend_rs2, pend_rd;
   logic wb_hit;
   logic byp_rs1, byp_rs2, byp_rd;
   logic hazard;
   logic accept;
   logic set_en;
   logic flush_clr_en;

   assign o_rf_idx1 = i_rs1;
   assign o_rf_idx2 = i_rs2;

   assign wb_hit = i_wb_enable && (i_wb_idx != REG_X0);

`ifdef WB_BYPASS_EN
   assign byp_rs1 = wb_hit && (i_wb_idx == i_rs1);
   assign byp_rs2 = wb_hit && (i_wb_idx == i_rs2);
   assign byp_rd  = wb_hit && (i_wb_idx == i_rd);
`else
   assign byp_rs1 = 1'b0;
   assign byp_rs2 = 1'b0;
   assign byp_rd  = 1'b0;
`endif

   // x0 never stalls; a register retiring this cycle only stalls without bypass.
   assign hazard = (pend_rs1 && (i_rs1 != REG_X0) && !byp_rs1) ||
                   (pend_rs2 && (i_rs2 != REG_X0) && !byp_rs2) ||
                   (i_rd_write && (i_rd != REG_X0) && pend_rd && !byp_rd);

   assign o_ready = (!valid_q || i_ready) && !hazard && !i_flush;
   assign accept  = i_valid && o_ready;

   assign set_en       = accept && i_rd_write && (i_rd != REG_X0);
   // Only a held instruction owns a pending bit that a flush must release.
   assign flush_clr_en = i_flush && valid_q && rd_write_q && (rd_q != REG_X0);

   reg_scoreboard u_scoreboard (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_set_en        (set_en),
      .i_set_idx       (i_rd),
      .i_clr_en        (wb_hit),
      .i_clr_idx       (i_wb_idx),
      .i_flush_clr_en  (flush_clr_en),
      .i_flush_clr_idx (rd_q),
      .i_lkp1_idx      (i_rs1),
      .i_lkp2_idx      (i_rs2),
      .i_lkp3_idx      (i_rd),
      .o_lkp1_pend     (pend_rs1),
      .o_lkp2_pend     (pend_rs2),
      .o_lkp3_pend     (pend_rd)
   );

   always_comb begin
      valid_d    = valid_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      rd_d       = rd_q;
      rd_write_d = rd_write_q;
      if (i_flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d    = 1'b1;
`ifdef WB_BYPASS_EN
         op1_d      = byp_rs1 ? i_wb_data : i_rf_data1;
         op2_d      = byp_rs2 ? i_wb_data : i_rf_data2;
`else
         op1_d      = i_rf_data1;
         op2_d      = i_rf_data2;
`endif
         pc_d       = i_pc;
         imm_d      = i_imm;
         rd_d       = i_rd;
         rd_write_d = i_rd_write;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q    <= 1'b0;
         op1_q      <= '0;
         op2_q      <= '0;
         pc_q       <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         rd_write_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         rd_q       <= rd_d;
         rd_write_q <= rd_write_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_op1      = op1_q;
   assign o_op2      = op2_q;
   assign o_pc       = pc_q;
   assign o_imm      = imm_q;
   assign o_rd       = rd_q;
   assign o_rd_write = rd_write_q;

`ifndef WB_BYPASS_EN
   // Writeback data is only consumed by the bypass path.
   logic unused_wb_data;
   assign unused_wb_data = ^i_wb_data;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_stage
// Scoreboard bench: the driver applies one instruction slot per cycle, a
// reference model of pending registers predicts o_ready/o_valid and queues the
// expected captured instruction; a monitor compares whatever the stage holds
// against the queue head and retires entries on fire or flush.
// -----------------------------------------------------------------------------
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [4:0]  i_rs1 = '0, i_rs2 = '0, i_rd = '0;
   logic        i_rd_write = 1'b0;
   logic [31:0] i_pc = '0, i_imm = '0;
   logic [4:0]  o_rf_idx1, o_rf_idx2;
   logic [31:0] i_rf_data1 = '0, i_rf_data2 = '0;
   logic        i_wb_enable = 1'b0;
   logic [4:0]  i_wb_idx = '0;
   logic [31:0] i_wb_data = '0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_op1, o_op2, o_pc, o_imm;
   logic [4:0]  o_rd;
   logic        o_rd_write;

   operand_fetch_stage dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_rs1      (i_rs1),
      .i_rs2      (i_rs2),
      .i_rd       (i_rd),
      .i_rd_write (i_rd_write),
      .i_pc       (i_pc),
      .i_imm      (i_imm),
      .o_rf_idx1  (o_rf_idx1),
      .o_rf_idx2  (o_rf_idx2),
      .i_rf_data1 (i_rf_data1),
      .i_rf_data2 (i_rf_data2),
      .i_wb_enable(i_wb_enable),
      .i_wb_idx   (i_wb_idx),
      .i_wb_data  (i_wb_data),
      .i_flush    (i_flush),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_op1      (o_op1),
      .o_op2      (o_op2),
      .o_pc       (o_pc),
      .o_imm      (o_imm),
      .o_rd       (o_rd),
      .o_rd_write (o_rd_write)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] op1, op2, pc, imm;
      logic [4:0]  rd;
      logic        rdw;
   } exp_t;

   exp_t exp_q[$];
   int   retire_q[$];
   bit   pend[32];
   bit   m_valid;
   logic [4:0] m_rd;
   bit   m_rdw;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) pend[r] = 1'b0;
      m_valid = 1'b0;
      m_rd    = '0;
      m_rdw   = 1'b0;
      exp_q.delete();
      retire_q.delete();
   endtask

   // Monitor: the held instruction must match the queue head every cycle it is
   // presented; it leaves the queue when it fires downstream or is flushed.
   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_o_valid", o_valid, 32'd0);
         end else begin
            chk("o_op1", o_op1, exp_q[0].op1);
            chk("o_op2", o_op2, exp_q[0].op2);
            chk("o_pc", o_pc, exp_q[0].pc);
            chk("o_imm", o_imm, exp_q[0].imm);
            chk("o_rd", o_rd, exp_q[0].rd);
            chk("o_rd_write", o_rd_write, exp_q[0].rdw);
            if (i_ready || i_flush) void'(exp_q.pop_front());
         end
      end
   end

   // One cycle: drive at posedge+1, evaluate the model at negedge.
   task automatic step(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit rdw, input bit rdy, input bit fl,
                       input bit wben, input logic [4:0] wbidx, input logic [31:0] wbdata,
                       input logic [31:0] d1, input logic [31:0] d2);
      logic [31:0] pc, imm, e1, e2;
      bit wbh, b1, b2, brd, hz, er, acc;
      int hits[$];
      pc  = $urandom;
      imm = $urandom;
      i_valid = v; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_rd_write = rdw;
      i_pc = pc; i_imm = imm; i_rf_data1 = d1; i_rf_data2 = d2;
      i_ready = rdy; i_flush = fl;
      i_wb_enable = wben; i_wb_idx = wbidx; i_wb_data = wbdata;
      @(negedge clk);
      wbh = wben && (wbidx != 0);
`ifdef WB_BYPASS_EN
      b1  = wbh && (wbidx == rs1);
      b2  = wbh && (wbidx == rs2);
      brd = wbh && (wbidx == rd);
`else
      b1 = 1'b0; b2 = 1'b0; brd = 1'b0;
`endif
      hz = (pend[rs1] && rs1 != 0 && !b1) || (pend[rs2] && rs2 != 0 && !b2) ||
           (rdw && rd != 0 && pend[rd] && !brd);
      er = (!m_valid || rdy) && !hz && !fl;
      chk("o_ready", o_ready, er);
      chk("o_valid", o_valid, m_valid);
      chk("o_rf_idx1", o_rf_idx1, rs1);
      chk("o_rf_idx2", o_rf_idx2, rs2);
      acc = v && er;
      if (m_valid && rdy && !fl && m_rdw && m_rd != 0) retire_q.push_back(int'(m_rd));
      if (wbh) begin
         pend[wbidx] = 1'b0;
         hits = retire_q.find_first_index(x) with (x == int'(wbidx));
         if (hits.size() != 0) retire_q.delete(hits[0]);
      end
      if (fl && m_valid && m_rdw && m_rd != 0) pend[m_rd] = 1'b0;
      if (acc) begin
         if (rdw && rd != 0) pend[rd] = 1'b1;
         e1 = b1 ? wbdata : d1;
         e2 = b2 ? wbdata : d2;
         exp_q.push_back('{op1: e1, op2: e2, pc: pc, imm: imm, rd: rd, rdw: rdw});
      end
      if (fl) m_valid = 1'b0;
      else if (acc) begin m_valid = 1'b1; m_rd = rd; m_rdw = rdw; end
      else if (rdy) m_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, rdy, 1'b0, 1'b0, 5'd0, 32'd0, $urandom, $urandom);
   endtask

   initial begin
      bit v, rdw, rdy, fl, wben;
      logic [4:0] rs1, rs2, rd, wbidx;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_o_valid", o_valid, 32'd0);
      chk("rst_o_op1", o_op1, 32'd0);
      chk("rst_o_op2", o_op2, 32'd0);
      chk("rst_o_pc", o_pc, 32'd0);
      chk("rst_o_imm", o_imm, 32'd0);
      chk("rst_o_rd", o_rd, 32'd0);
      chk("rst_o_rd_write", o_rd_write, 32'd0);
      rst_n = 1'b1;

      // Basic issue: rs1=1, rs2=2, rd=3
      step(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 5'd0, 32'd0, 32'h11, 32'h22);
      // RAW on x3: stall while pending, then writeback 0xDEAD
      step(1, 5'd3, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 32'd0, 32'h33, 32'h0);
      step(1, 5'd3, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 32'd0, 32'h33, 32'h0);
      step(1, 5'd3, 5'd0, 5'd0, 0, 1, 0, 1, 5'd3, 32'hDEAD, 32'h44, 32'h0);
      step(1, 5'd3, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 32'd0, 32'h55, 32'h0);
      idle(1);
      // x0 handling
      step(1, 5'd1, 5'd1, 5'd0, 1, 1, 0, 0, 5'd0, 32'd0, $urandom, $urandom);
      step(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 32'd0, $urandom, $urandom);
      step(1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 5'd0, 32'hBEEF, $urandom, $urandom);
      idle(1);
      // Backpressure for three cycles, then release
      step(1, 5'd1, 5'd2, 5'd4, 1, 1, 0, 0, 5'd0, 32'd0, $urandom, $urandom);
      repeat (3) step(1, 5'd9, 5'd10, 5'd0, 0, 0, 0, 0, 5'd0, 32'd0, $urandom, $urandom);
      step(1, 5'd9, 5'd10, 5'd0, 0, 1, 0, 0, 5'd0, 32'd0, $urandom, $urandom);
      step(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 5'd4, 32'd0, $urandom, $urandom);
      // Flush of a held writer to x7
      step(1, 5'd1, 5'd1, 5'd7, 1, 1, 0, 0, 5'd0, 32'd0, $urandom, $urandom);
      step(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 32'd0, $urandom, $urandom);
      step(1, 5'd7, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 32'd0, $urandom, $urandom);
      idle(1);
      // Reset mid-operation with x5 pending and an instruction held
      step(1, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0, 5'd0, 32'd0, $urandom, $urandom);
      i_rs1 = 5'd5; i_rs2 = 5'd0; i_rd_write = 1'b0; i_flush = 1'b0; i_wb_enable = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_o_valid", o_valid, 32'd0);
      chk("async_rst_o_ready", o_ready, 32'd1);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1, 5'd5, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 32'd0, $urandom, $urandom);
      idle(1);

      // Randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         v    = ($urandom_range(0, 3) != 0);
         rs1  = 5'($urandom_range(0, 7));
         rs2  = 5'($urandom_range(0, 7));
         rd   = 5'($urandom_range(0, 7));
         rdw  = ($urandom_range(0, 2) != 0);
         rdy  = ($urandom_range(0, 9) < 7);
         fl   = ($urandom_range(0, 24) == 0);
         if (fl) rdy = 1'b0;
         wben = 1'b0;
         wbidx = '0;
         if (retire_q.size() != 0 && $urandom_range(0, 2) == 0) begin
            wben  = 1'b1;
            wbidx = 5'(retire_q[$urandom_range(0, retire_q.size() - 1)]);
         end else if ($urandom_range(0, 15) == 0) begin
            wben = 1'b1;
         end
         step(v, rs1, rs2, rd, rdw, rdy, fl, wben, wbidx, $urandom, $urandom, $urandom);
      end

      // Drain: retire everything still outstanding
      for (int n = 0; n < 40; n++) begin
         wben = (retire_q.size() != 0);
         wbidx = wben ? 5'(retire_q[0]) : 5'd0;
         step(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, wben, wbidx, $urandom, $urandom, $urandom);
      end
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("final_o_valid", o_valid, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
